// File: rtl/mario_input_conditioner.sv
// Turns the three raw active-low push-keys into clean left/right/jump commands for the Mario mover:
// two-flop sync, per-key debounce, last-pressed-wins direction, time-limited non-repeating jump.
//
// state          | meaning
// D_IDLE         | no direction commanded (no key, or both pressed from idle)
// D_LEFT         | left commanded
// D_RIGHT        | right commanded
// J_IDLE         | jump released, ready to fire on the next debounced press
// J_ACTIVE       | jump_n driven low, hold timer running
// J_WAIT_RELEASE | hold limit reached, jump_n high until the key is released
module mario_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int JUMP_HOLD_MAX   = 6_250_000
) (
   input  logic vga_clock,
   input  logic reset,
   input  logic key_left_n,
   input  logic key_right_n,
   input  logic key_jump_n,
   output logic left,
   output logic right,
   output logic jump_n
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int JT_W = $clog2(JUMP_HOLD_MAX + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [JT_W-1:0] JT_LAST = JT_W'(JUMP_HOLD_MAX - 1);

   typedef enum logic [1:0] {D_IDLE, D_LEFT, D_RIGHT} dir_state_t;
   typedef enum logic [1:0] {J_IDLE, J_ACTIVE, J_WAIT_RELEASE} jmp_state_t;

   // bit 0 = left, bit 1 = right, bit 2 = jump
   logic [2:0]      key_raw_n;
   logic [2:0]      sync1_n;
   logic [2:0]      sync2_n;
   logic [2:0]      pressed;
   logic [2:0]      db;
   logic [2:0]      db_q;
   logic [2:0]      rise;
   logic [DB_W-1:0] db_cnt [3];

   dir_state_t      dir_state, dir_next;
   jmp_state_t      jmp_state, jmp_next;
   logic [JT_W-1:0] jmp_timer;

   assign key_raw_n = {key_jump_n, key_right_n, key_left_n};
   assign pressed   = ~sync2_n;
   assign rise      = db & ~db_q;

   always_ff @(posedge vga_clock) begin
      if (reset) begin
         sync1_n <= '1;
         sync2_n <= '1;
         db_q    <= '0;
      end else begin
         sync1_n <= key_raw_n;
         sync2_n <= sync1_n;
         db_q    <= db;
      end
   end

   // A level must differ from the debounced value for DEBOUNCE_CYCLES consecutive cycles to flip it.
   always_ff @(posedge vga_clock) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            db_cnt[i] <= '0;
            db[i]     <= 1'b0;
         end else if (pressed[i] == db[i]) begin
            db_cnt[i] <= '0;
         end else if (db_cnt[i] == DB_LAST) begin
            db_cnt[i] <= '0;
            db[i]     <= pressed[i];
         end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge vga_clock) begin
      if (reset) begin
         dir_state <= D_IDLE;
         jmp_state <= J_IDLE;
         jmp_timer <= '0;
      end else begin
         dir_state <= dir_next;
         jmp_state <= jmp_next;
         if (jmp_state == J_ACTIVE) jmp_timer <= jmp_timer + 1'b1;
         else                       jmp_timer <= '0;
      end
   end

   always_comb begin
      dir_next = dir_state;
      case (dir_state)
         D_IDLE: begin
            if (db[0] && !db[1])      dir_next = D_LEFT;
            else if (db[1] && !db[0]) dir_next = D_RIGHT;
         end
         D_LEFT: begin
            if (rise[1])     dir_next = D_RIGHT;
            else if (!db[0]) dir_next = db[1] ? D_RIGHT : D_IDLE;
         end
         D_RIGHT: begin
            if (rise[0])     dir_next = D_LEFT;
            else if (!db[1]) dir_next = db[0] ? D_LEFT : D_IDLE;
         end
         default: dir_next = D_IDLE;
      endcase
   end

   // Release wins over the hold limit when both land in the same cycle.
   always_comb begin
      jmp_next = jmp_state;
      case (jmp_state)
         J_IDLE:         if (db[2]) jmp_next = J_ACTIVE;
         J_ACTIVE: begin
            if (!db[2])                  jmp_next = J_IDLE;
            else if (jmp_timer == JT_LAST) jmp_next = J_WAIT_RELEASE;
         end
         J_WAIT_RELEASE: if (!db[2]) jmp_next = J_IDLE;
         default:        jmp_next = J_IDLE;
      endcase
   end

   // Outputs decode registered state directly, so they are glitch-free flop outputs.
   always_comb begin
      left   = (dir_state == D_LEFT);
      right  = (dir_state == D_RIGHT);
      jump_n = (jmp_state != J_ACTIVE);
   end

endmodule

// File: tb/tb_mario_input_conditioner.sv
// Directed bench for mario_input_conditioner with DEBOUNCE_CYCLES=4, JUMP_HOLD_MAX=10.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_mario_input_conditioner;

   logic vga_clock = 1'b0;
   logic reset;
   logic key_left_n, key_right_n, key_jump_n;
   logic left, right, jump_n;

   int tests  = 0;
   int errors = 0;

   typedef struct {
      logic kl;
      logic kr;
      logic kj;
      int   cycles;
      logic el;
      logic er;
      logic ejn;
   } vec_t;

   vec_t vecs [13];

   mario_input_conditioner #(
      .DEBOUNCE_CYCLES(4),
      .JUMP_HOLD_MAX  (10)
   ) dut (
      .vga_clock  (vga_clock),
      .reset      (reset),
      .key_left_n (key_left_n),
      .key_right_n(key_right_n),
      .key_jump_n (key_jump_n),
      .left       (left),
      .right      (right),
      .jump_n     (jump_n)
   );

   always #5 vga_clock = ~vga_clock;

   task automatic tick;
      @(posedge vga_clock);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
      $fatal(1, "timeout");
   end

   initial begin
      int low;
      int first;
      int seen;

      //            kl    kr    kj  cyc  el    er    ejn
      vecs[0]  = '{1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b1};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b1};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 10, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 1'b1, 10, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 1'b0,  8, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b0, 20, 1'b1, 1'b0, 1'b1};
      vecs[12] = '{1'b1, 1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b1};

      reset = 1'b1;
      key_left_n = 1'b1; key_right_n = 1'b1; key_jump_n = 1'b1;
      repeat (3) tick;
      chk("reset_left",   int'(left),   0);
      chk("reset_right",  int'(right),  0);
      chk("reset_jump_n", int'(jump_n), 1);
      reset = 1'b0;
      repeat (2) tick;

      // clean press: left must rise exactly 7 edges after the raw edge
      key_left_n = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick;
         chk($sformatf("left_latency_e%0d", k), int'(left), int'(k >= 7));
      end
      key_left_n = 1'b1;
      repeat (10) tick;
      chk("left_release", int'(left), 0);

      // 3-cycle glitch must never reach the output
      key_left_n = 1'b0;
      seen = 0;
      for (int k = 1; k <= 15; k++) begin
         tick;
         if (left) seen = 1;
         if (k == 3) key_left_n = 1'b1;
      end
      chk("glitch3_no_left", seen, 0);
      repeat (5) tick;

      // 1-cycle bounce during a press restarts the count: left rises at edge 10
      key_left_n = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         tick;
         chk($sformatf("bounce_left_e%0d", k), int'(left), int'(k >= 10));
         if (k == 2) key_left_n = 1'b1;
         if (k == 3) key_left_n = 1'b0;
      end
      key_left_n = 1'b1;
      repeat (10) tick;

      for (int i = 0; i < 13; i++) begin
         key_left_n  = vecs[i].kl;
         key_right_n = vecs[i].kr;
         key_jump_n  = vecs[i].kj;
         repeat (vecs[i].cycles) tick;
         chk($sformatf("vec%0d_left",   i), int'(left),   int'(vecs[i].el));
         chk($sformatf("vec%0d_right",  i), int'(right),  int'(vecs[i].er));
         chk($sformatf("vec%0d_jump_n", i), int'(jump_n), int'(vecs[i].ejn));
      end

      // long hold: exactly 10 low cycles starting at edge 7, then high while held
      key_jump_n = 1'b0;
      low = 0; first = 0;
      for (int k = 1; k <= 30; k++) begin
         tick;
         if (!jump_n) begin
            low++;
            if (first == 0) first = k;
         end
      end
      chk("hold_low_cycles", low, 10);
      chk("hold_first_low", first, 7);
      chk("hold_wait_high", int'(jump_n), 1);
      key_jump_n = 1'b1;
      repeat (10) tick;
      chk("hold_released", int'(jump_n), 1);

      key_jump_n = 1'b0;
      low = 0;
      for (int k = 1; k <= 30; k++) begin
         tick;
         if (!jump_n) low++;
      end
      chk("repress_low_cycles", low, 10);
      key_jump_n = 1'b1;
      repeat (10) tick;

      // tap: low from edge 7 until the debounced release at edge 13
      key_jump_n = 1'b0;
      low = 0;
      for (int k = 1; k <= 20; k++) begin
         tick;
         if (!jump_n) low++;
         if (k == 6) key_jump_n = 1'b1;
      end
      chk("tap_low_cycles", low, 6);
      repeat (5) tick;

      // reset while jumping with left held
      key_left_n = 1'b0; key_jump_n = 1'b0;
      repeat (9) tick;
      chk("pre_reset_left",   int'(left),   1);
      chk("pre_reset_jump_n", int'(jump_n), 0);
      reset = 1'b1;
      tick;
      chk("post_reset_left",   int'(left),   0);
      chk("post_reset_right",  int'(right),  0);
      chk("post_reset_jump_n", int'(jump_n), 1);
      reset = 1'b0;
      low = 0;
      for (int k = 1; k <= 30; k++) begin
         tick;
         if (!jump_n) low++;
         if (k <= 8) begin
            chk($sformatf("rearm_left_e%0d", k),   int'(left),   int'(k >= 7));
            chk($sformatf("rearm_jump_n_e%0d", k), int'(jump_n), int'(k < 7));
         end
      end
      chk("rearm_jump_low_cycles", low, 10);
      key_left_n = 1'b1; key_jump_n = 1'b1;
      repeat (10) tick;
      chk("final_idle_left", int'(left), 0);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
